// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a shadow/display double buffer,
// anti-ghost blanking, leading-zero suppression and selectable output polarity.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GHOST_CYC    = 2,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GHOST = CW'(GHOST_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic          INV       = COMMON_ANODE;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_dp;
  logic [4*DIGITS-1:0] dsp_val;
  logic [DIGITS-1:0]   dsp_dp;

  logic                slot_end;
  logic                frame_wrap;
  logic                ghost;

  logic [DIGITS-1:0]   lz_blank;
  logic                upper_zero;
  logic [DIGITS-1:0]   sel_hot;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;

  logic [6:0]          seg_nx;
  logic                dp_nx;
  logic [DIGITS-1:0]   sel_nx;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h7E;
      4'h1:    return 7'h30;
      4'h2:    return 7'h6D;
      4'h3:    return 7'h79;
      4'h4:    return 7'h33;
      4'h5:    return 7'h5B;
      4'h6:    return 7'h5F;
      4'h7:    return 7'h70;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h7B;
      4'hA:    return 7'h77;
      4'hB:    return 7'h1F;
      4'hC:    return 7'h4E;
      4'hD:    return 7'h3D;
      4'hE:    return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign ghost      = (cnt < CNT_GHOST);

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero & (dsp_val[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz & upper_zero;
    end
  end

  always_comb begin
    sel_hot   = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_hot[i] = 1'b1;
        cur_nib    = dsp_val[4*i +: 4];
        cur_dp     = dsp_dp[i];
        cur_blank  = lz_blank[i];
      end
    end
  end

  always_comb begin
    seg_nx = '0;
    dp_nx  = 1'b0;
    sel_nx = '0;
    if (!ghost) begin
      seg_nx = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
      dp_nx  = cur_dp;
      sel_nx = sel_hot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      dsp_val    <= '0;
      dsp_dp     <= '0;
      seg        <= {7{INV}};
      dp         <= INV;
      digit_sel  <= {DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end

      // Display only changes at the frame boundary; a load landing on it bypasses the shadow.
      if (frame_wrap) begin
        dsp_val <= load ? value : sh_val;
        dsp_dp  <= load ? dp_in : sh_dp;
      end

      seg        <= seg_nx ^ {7{INV}};
      dp         <= dp_nx ^ INV;
      digit_sel  <= sel_nx ^ {DIGITS{INV}};
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: CA and CC instances in parallel, checked every cycle
// against a frame/slot-position reference model plus a table of display vectors.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0]  seg_ca, seg_cc;
  logic        dp_ca, dp_cc;
  logic [3:0]  sel_ca, sel_cc;
  logic        fd_ca, fd_cc;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .GHOST_CYC(2), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_ca), .dp(dp_ca), .digit_sel(sel_ca), .frame_done(fd_ca)
  );

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .GHOST_CYC(2), .COMMON_ANODE(1'b0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_cc), .dp(dp_cc), .digit_sel(sel_cc), .frame_done(fd_cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  logic [6:0] seg_rom [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference state: position in cycles since reset release, plus buffered values.
  int          p = 0;
  logic [15:0] m_sh_val = '0, m_dsp_val = '0;
  logic [3:0]  m_sh_dp  = '0, m_dsp_dp  = '0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (pos %0d)", name, act, exp, p);
    end
  endfunction

  task automatic tick();
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;
    logic        e_fd;
    logic [15:0] up;
    int slot, c;
    e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fd = 1'b0;
    if (rst_n) begin
      slot = (p / 8) % 4;
      c    = p % 8;
      e_fd = ((p % 32) == 31);
      if (c >= 2) begin
        up    = m_dsp_val >> (4 * slot);
        e_seg = (blank_lz && slot != 0 && up == 16'h0) ? 7'h00 : seg_rom[up[3:0]];
        e_dp  = m_dsp_dp[slot];
        e_sel = 4'(1 << slot);
      end
    end
    if (!rst_n) begin
      p = 0;
      m_sh_val = '0; m_dsp_val = '0; m_sh_dp = '0; m_dsp_dp = '0;
    end else begin
      if (load) begin
        m_sh_val = value;
        m_sh_dp  = dp_in;
      end
      if ((p % 32) == 31) begin
        m_dsp_val = m_sh_val;
        m_dsp_dp  = m_sh_dp;
      end
      p++;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      chk("rst_seg_ca", {1'b0, seg_ca}, 8'h7F);
      chk("rst_dp_ca",  {7'b0, dp_ca},  8'h01);
      chk("rst_sel_ca", {4'b0, sel_ca}, 8'h0F);
    end else begin
      chk("seg_ca", {1'b0, seg_ca}, {1'b0, ~e_seg});
      chk("dp_ca",  {7'b0, dp_ca},  {7'b0, ~e_dp});
      chk("sel_ca", {4'b0, sel_ca}, {4'b0, ~e_sel});
    end
    chk("fd_ca",  {7'b0, fd_ca},  {7'b0, e_fd});
    chk("seg_cc", {1'b0, seg_cc}, {1'b0, e_seg});
    chk("dp_cc",  {7'b0, dp_cc},  {7'b0, e_dp});
    chk("sel_cc", {4'b0, sel_cc}, {4'b0, e_sel});
    chk("fd_cc",  {7'b0, fd_cc},  {7'b0, e_fd});
  endtask

  task automatic run_to(input int pos);
    int n = 0;
    while ((p % 32) != pos && n < 64) begin
      tick();
      n++;
    end
  endtask

  // Checks the digit currently shown against an active-high expectation on both polarities.
  task automatic shows(string name, input int digit, input logic [6:0] e_seg, input logic e_dp);
    logic [3:0] e_sel;
    e_sel = 4'b0001 << digit;
    chk({name, "_seg_cc"}, {1'b0, seg_cc}, {1'b0, e_seg});
    chk({name, "_seg_ca"}, {1'b0, seg_ca}, {1'b0, ~e_seg});
    chk({name, "_dp_ca"},  {7'b0, dp_ca},  {7'b0, ~e_dp});
    chk({name, "_sel_cc"}, {4'b0, sel_cc}, {4'b0, e_sel});
    chk({name, "_sel_ca"}, {4'b0, sel_ca}, {4'b0, ~e_sel});
  endtask

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic        blz;
    int          digit;
    logic [6:0]  e_seg;
    logic        e_dp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [15:0] val, logic [3:0] dpv, logic blz, int digit,
                              logic [6:0] e_seg, logic e_dp);
    vec_t v;
    v.val = val; v.dpv = dpv; v.blz = blz; v.digit = digit; v.e_seg = e_seg; v.e_dp = e_dp;
    vecs.push_back(v);
  endfunction

  initial begin
    add(16'h1234, 4'b0100, 1'b1, 0, 7'h33, 1'b0);
    add(16'h1234, 4'b0100, 1'b1, 1, 7'h79, 1'b0);
    add(16'h1234, 4'b0100, 1'b1, 2, 7'h6D, 1'b1);
    add(16'h1234, 4'b0100, 1'b1, 3, 7'h30, 1'b0);
    add(16'h0040, 4'b0000, 1'b1, 3, 7'h00, 1'b0);
    add(16'h0040, 4'b0100, 1'b1, 2, 7'h00, 1'b1);
    add(16'h0040, 4'b0000, 1'b1, 1, 7'h33, 1'b0);
    add(16'h0040, 4'b0000, 1'b1, 0, 7'h7E, 1'b0);
    add(16'h0040, 4'b0000, 1'b0, 3, 7'h7E, 1'b0);
    add(16'h0040, 4'b0000, 1'b0, 2, 7'h7E, 1'b0);
    add(16'h0000, 4'b0001, 1'b1, 0, 7'h7E, 1'b1);
    add(16'h0000, 4'b0000, 1'b1, 1, 7'h00, 1'b0);
    add(16'h0000, 4'b0000, 1'b0, 0, 7'h7E, 1'b0);
    add(16'h0001, 4'b0000, 1'b0, 0, 7'h30, 1'b0);
    add(16'h0002, 4'b0000, 1'b0, 0, 7'h6D, 1'b0);
    add(16'h0003, 4'b0000, 1'b0, 0, 7'h79, 1'b0);
    add(16'h0004, 4'b0000, 1'b0, 0, 7'h33, 1'b0);
    add(16'h0005, 4'b0000, 1'b0, 0, 7'h5B, 1'b0);
    add(16'h0006, 4'b0000, 1'b0, 0, 7'h5F, 1'b0);
    add(16'h0007, 4'b0000, 1'b0, 0, 7'h70, 1'b0);
    add(16'h0008, 4'b0000, 1'b0, 0, 7'h7F, 1'b0);
    add(16'h0009, 4'b0000, 1'b0, 0, 7'h7B, 1'b0);
    add(16'h000A, 4'b0000, 1'b0, 0, 7'h77, 1'b0);
    add(16'h000B, 4'b0000, 1'b0, 0, 7'h1F, 1'b0);
    add(16'h000C, 4'b0000, 1'b0, 0, 7'h4E, 1'b0);
    add(16'h000D, 4'b0000, 1'b0, 0, 7'h3D, 1'b0);
    add(16'h000E, 4'b0000, 1'b0, 0, 7'h4F, 1'b0);
    add(16'h000F, 4'b0000, 1'b0, 0, 7'h47, 1'b0);

    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Load in the first cycle after release; frame 1 still shows zeros.
    value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    run_to(5);  shows("f1_d0", 0, 7'h7E, 1'b0);
    run_to(13); shows("f1_d1", 1, 7'h00, 1'b0);
    run_to(0);
    chk("f1_frame_done", {7'b0, fd_ca}, 8'h01);
    run_to(5);  shows("f2_d0", 0, 7'h33, 1'b0);
    run_to(13); shows("f2_d1", 1, 7'h79, 1'b0);
    run_to(21); shows("f2_d2", 2, 7'h6D, 1'b1);

    foreach (vecs[j]) begin
      value = vecs[j].val; dp_in = vecs[j].dpv; blank_lz = vecs[j].blz; load = 1'b1;
      tick();
      load = 1'b0;
      run_to(0);
      run_to(8 * vecs[j].digit + 5);
      shows($sformatf("vec%0d", j), vecs[j].digit, vecs[j].e_seg, vecs[j].e_dp);
    end

    // Two loads inside one frame: only the last one appears.
    blank_lz = 1'b0; dp_in = 4'b0000;
    run_to(0);
    run_to(10); value = 16'hAAAA; load = 1'b1; tick(); load = 1'b0;
    run_to(20); value = 16'h5555; load = 1'b1; tick(); load = 1'b0;
    value = 16'h0000;
    run_to(0);
    run_to(5);  shows("tear_d0", 0, 7'h5B, 1'b0);
    run_to(29); shows("tear_d3", 3, 7'h5B, 1'b0);

    // Load exactly on the wrap cycle goes straight to the display.
    run_to(31); value = 16'h9C3E; dp_in = 4'b1000; load = 1'b1; tick(); load = 1'b0;
    value = 16'h0000; dp_in = 4'b0000;
    chk("bypass_frame_done", {7'b0, fd_cc}, 8'h01);
    run_to(5);  shows("bypass_d0", 0, 7'h4F, 1'b0);
    run_to(21); shows("bypass_d2", 2, 7'h4E, 1'b0);
    run_to(29); shows("bypass_d3", 3, 7'h7B, 1'b1);

    // Reset during the digit-2 slot clears the display and restarts at digit 0.
    run_to(19);
    rst_n = 1'b0;
    tick();
    chk("midrst_seg_cc", {1'b0, seg_cc}, 8'h00);
    chk("midrst_sel_cc", {4'b0, sel_cc}, 8'h00);
    tick();
    rst_n = 1'b1;
    run_to(5);  shows("midrst_d0", 0, 7'h7E, 1'b0);
    run_to(29); shows("midrst_d3", 3, 7'h7E, 1'b0);

    // Random traffic against the reference model.
    for (int i = 0; i < 900; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
      if ($urandom_range(0, 4) == 0) value[7:4] = 4'h0;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; load = 1'b0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
